fetch_stage: RTL and testbench

- Instruction-fetch front end of the 5-stage pipeline; sits directly upstream of decode and produces the FD latch contents.
- Owns the PC register and drives the imem address. Imem read is combinational: q_imem corresponds to address_imem in the same cycle.
- Predecodes j/jal for zero-penalty redirect.
- Accepts stall from the hazard logic and redirect/flush from execute (taken branch, jr).

---
 rtl/fetch_stage.sv | 113 +++++++++++
 tb/tb_fetch_stage.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// Purpose: instruction-fetch front end; owns the PC, drives imem, predecodes j/jal, loads the FD latch.
// Latency: PC-to-FD is 1 cycle; j/jal redirect with no bubble; execute redirect costs exactly one FD bubble.
// Backpressure: stall holds PC and FD; redirect overrides stall and replaces FD with a bubble.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'd0,
  parameter logic [31:0] NOP_WORD = 32'd0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic [31:0] address_imem,
  input  logic [31:0] q_imem,
  output logic [31:0] fd_pc,
  output logic [31:0] fd_ir,
  output logic        fd_valid,
  output logic [31:0] fetch_count,
  output logic [31:0] flush_count
);

  localparam logic [4:0]  OP_J     = 5'b00001;
  localparam logic [4:0]  OP_JAL   = 5'b00011;
  localparam logic [31:0] CNT_MAX  = 32'hFFFF_FFFF;

  // Architectural state
  logic [31:0] r_pc;
  logic [31:0] r_fd_pc;
  logic [31:0] r_fd_ir;
  logic        r_fd_valid;
  logic [31:0] r_fetch_count;
  logic [31:0] r_flush_count;

  // Predecode and next-PC datapath
  logic [4:0]  w_opcode;
  logic        w_is_jump;
  logic [31:0] w_jump_target;
  logic [31:0] w_pc_plus1;
  logic [31:0] w_next_pc;
  logic        w_flush;
  logic        w_advance;

  // Only the opcode field is inspected; the j/jal target is the low 27 bits, zero-extended.
  assign w_opcode      = q_imem[31:27];
  assign w_is_jump     = (w_opcode == OP_J) || (w_opcode == OP_JAL);
  assign w_jump_target = {5'b0, q_imem[26:0]};

  // 32-bit increment wraps naturally from all-ones to zero.
  assign w_pc_plus1 = r_pc + 32'd1;

  // Redirect beats stall; a real fetch happens only when neither is active.
  assign w_flush   = redirect_valid;
  assign w_advance = !redirect_valid && !stall;

  // Select the next PC: redirect, then hold on stall, then predecoded jump, then sequential.
  always_comb begin
    w_next_pc = r_pc;
    if (w_flush) begin
      w_next_pc = redirect_target;
    end else if (w_advance) begin
      w_next_pc = w_is_jump ? w_jump_target : w_pc_plus1;
    end
  end

  // PC register; imem address comes only from here, never from q_imem.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_pc <= RESET_PC;
    end else begin
      r_pc <= w_next_pc;
    end
  end

  // FD latch: bubble on redirect, hold on stall, otherwise capture the fetched word and PC+1.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_fd_ir    <= NOP_WORD;
      r_fd_pc    <= 32'd0;
      r_fd_valid <= 1'b0;
    end else if (w_flush) begin
      r_fd_ir    <= NOP_WORD;
      r_fd_pc    <= 32'd0;
      r_fd_valid <= 1'b0;
    end else if (w_advance) begin
      r_fd_ir    <= q_imem;
      r_fd_pc    <= w_pc_plus1;
      r_fd_valid <= 1'b1;
    end
  end

  // Saturating event counters: valid FD loads and redirect flushes.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_fetch_count <= 32'd0;
      r_flush_count <= 32'd0;
    end else begin
      if (w_advance && (r_fetch_count != CNT_MAX)) begin
        r_fetch_count <= r_fetch_count + 32'd1;
      end
      if (w_flush && (r_flush_count != CNT_MAX)) begin
        r_flush_count <= r_flush_count + 32'd1;
      end
    end
  end

  assign address_imem = r_pc;
  assign fd_pc        = r_fd_pc;
  assign fd_ir        = r_fd_ir;
  assign fd_valid     = r_fd_valid;
  assign fetch_count  = r_fetch_count;
  assign flush_count  = r_flush_count;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios then random stall/redirect traffic.
// An expectation per clock edge is queued when stimulus is applied; a monitor pops and compares after each edge.
module tb_fetch_stage;

  logic        clock = 1'b0;
  logic        reset;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic [31:0] address_imem;
  logic [31:0] q_imem;
  logic [31:0] fd_pc;
  logic [31:0] fd_ir;
  logic        fd_valid;
  logic [31:0] fetch_count;
  logic [31:0] flush_count;

  logic [31:0] mem [256];

  fetch_stage #(.RESET_PC(32'd0), .NOP_WORD(32'd0)) dut (
    .clock          (clock),
    .reset          (reset),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_target(redirect_target),
    .address_imem   (address_imem),
    .q_imem         (q_imem),
    .fd_pc          (fd_pc),
    .fd_ir          (fd_ir),
    .fd_valid       (fd_valid),
    .fetch_count    (fetch_count),
    .flush_count    (flush_count)
  );

  // Combinational instruction memory, aliased every 256 words.
  assign q_imem = mem[address_imem[7:0]];

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] ir;
    logic [31:0] fpc;
    logic        v;
    longint      fc;
    longint      flc;
  } exp_t;

  exp_t sb[$];

  // Reference state: counters kept unbounded, clamped only when compared.
  logic [31:0] m_pc;
  logic [31:0] m_ir;
  logic [31:0] m_fpc;
  logic        m_v;
  longint      m_fc;
  longint      m_flc;

  int n_pass  = 0;
  int n_total = 0;
  bit mon_en  = 1'b0;

  function automatic logic [31:0] sat(input longint c);
    if (c > 64'h0000_0000_FFFF_FFFF) return 32'hFFFF_FFFF;
    return 32'(c);
  endfunction

  function automatic logic [31:0] rand_plain();
    logic [31:0] w;
    w = $urandom();
    if (w[31:27] == 5'b00001 || w[31:27] == 5'b00011) w[31] = 1'b1;
    return w;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_addr"},   address_imem, 32'd0);
    chk({tag, "_fd_ir"},  fd_ir, 32'd0);
    chk({tag, "_fd_pc"},  fd_pc, 32'd0);
    chk({tag, "_fd_v"},   {31'b0, fd_valid}, 32'd0);
    chk({tag, "_fcnt"},   fetch_count, 32'd0);
    chk({tag, "_flcnt"},  flush_count, 32'd0);
  endtask

  task automatic model_reset();
    m_pc  = 32'd0;
    m_ir  = 32'd0;
    m_fpc = 32'd0;
    m_v   = 1'b0;
    m_fc  = 0;
    m_flc = 0;
  endtask

  // Apply the fetch rules for one edge and queue the resulting visible state.
  task automatic model_step(input bit st, input bit rd, input logic [31:0] tg);
    logic [31:0] word;
    logic [31:0] seq;
    exp_t e;
    word = mem[m_pc[7:0]];
    seq  = m_pc + 32'd1;
    if (rd) begin
      m_pc  = tg;
      m_ir  = 32'd0;
      m_fpc = 32'd0;
      m_v   = 1'b0;
      m_flc = m_flc + 1;
    end else if (!st) begin
      m_ir  = word;
      m_fpc = seq;
      m_v   = 1'b1;
      m_fc  = m_fc + 1;
      if (word[31:27] == 5'd1 || word[31:27] == 5'd3) m_pc = {5'b0, word[26:0]};
      else m_pc = seq;
    end
    e.pc  = m_pc;
    e.ir  = m_ir;
    e.fpc = m_fpc;
    e.v   = m_v;
    e.fc  = m_fc;
    e.flc = m_flc;
    sb.push_back(e);
  endtask

  task automatic step(input bit st, input bit rd, input logic [31:0] tg);
    @(negedge clock);
    stall           = st;
    redirect_valid  = rd;
    redirect_target = tg;
    model_step(st, rd, tg);
    mon_en = 1'b1;
  endtask

  // Monitor: after every rising edge, compare the DUT against the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clock);
      #1;
      if (mon_en) begin
        if (sb.size() == 0) begin
          n_total++;
          $display("FAIL sb_underflow: got empty queue expected an entry at %0t", $time);
        end else begin
          e = sb.pop_front();
          chk("addr",   address_imem, e.pc);
          chk("fd_ir",  fd_ir, e.ir);
          chk("fd_pc",  fd_pc, e.fpc);
          chk("fd_v",   {31'b0, fd_valid}, {31'b0, e.v});
          chk("fcnt",   fetch_count, sat(e.fc));
          chk("flcnt",  flush_count, sat(e.flc));
        end
      end
    end
  end

  initial begin
    bit          st;
    bit          rd;
    logic [31:0] tg;
    int          r;

    reset           = 1'b1;
    stall           = 1'b0;
    redirect_valid  = 1'b0;
    redirect_target = 32'd0;

    for (int i = 0; i < 256; i++) begin
      r = $urandom_range(0, 99);
      if (r < 70)      mem[i] = rand_plain();
      else if (r < 85) mem[i] = {5'b00001, 27'($urandom_range(0, 255))};
      else             mem[i] = {5'b00011, 27'($urandom())};
    end
    for (int i = 0; i < 5; i++) mem[i] = 32'h2000_0000 | 32'(i);
    mem[5]   = 32'h0800_0014;   // j 20
    mem[6]   = 32'h2000_0006;
    mem[7]   = 32'h2000_0007;
    mem[8]   = 32'h1800_0032;   // jal 50
    mem[20]  = 32'h0800_0007;   // j 7
    mem[39]  = 32'h2000_0027;
    mem[255] = 32'h2000_00FF;

    #2;
    chk_reset("reset_init");

    @(posedge clock);
    #2;
    reset = 1'b0;
    model_reset();

    // Sequential fetch 0..4, j at 5 to 20, j at 20 to 7.
    for (int i = 0; i < 7; i++) step(1'b0, 1'b0, 32'd0);
    // Stall three cycles at PC=7, then release.
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 32'd0);
    step(1'b0, 1'b0, 32'd0);
    // Redirect together with stall while a jal sits at q_imem.
    step(1'b1, 1'b1, 32'd100);
    // PC wrap from all-ones.
    step(1'b0, 1'b1, 32'hFFFF_FFFF);
    step(1'b0, 1'b0, 32'd0);
    step(1'b0, 1'b0, 32'd0);

    // Random stall/redirect traffic.
    for (int i = 0; i < 400; i++) begin
      st = ($urandom_range(0, 4) == 0);
      rd = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 7) == 0)      tg = 32'hFFFF_FFFF;
      else if ($urandom_range(0, 1) == 1) tg = 32'($urandom_range(0, 255));
      else                                tg = $urandom();
      step(st, rd, tg);
    end

    // Reach PC=40 with a valid FD, then reset mid-cycle.
    step(1'b0, 1'b1, 32'd39);
    step(1'b0, 1'b0, 32'd0);
    @(posedge clock);
    #3;
    chk("pre_reset_addr", address_imem, 32'd40);
    chk("pre_reset_fd_v", {31'b0, fd_valid}, 32'd1);
    mon_en = 1'b0;
    reset  = 1'b1;
    #1;
    chk_reset("reset_async");

    @(posedge clock);
    #2;
    reset = 1'b0;
    model_reset();
    #1;
    chk("post_reset_addr", address_imem, 32'd0);
    step(1'b0, 1'b0, 32'd0);
    step(1'b0, 1'b0, 32'd0);

    @(posedge clock);
    #3;
    mon_en = 1'b0;
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
